dft_bfp_denorm: RTL
===================

DFT_BFP_DENORM -- requirements
Module: dft_bfp_denorm

Interface
REQ-001 SHALL provide parameter IN_W, default 18: width of the signed input real/imag samples.
REQ-002 SHALL provide parameter OUT_W, default 30: width of the signed denormalised output samples.
REQ-003 SHALL provide parameter EXP_W, default 4: width of the block-exponent input.
REQ-004 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid/in_sop/in_eop  in  1 each  DFT source beat, start of frame, end of frame.
REQ-007 SHALL have ports in_real/in_imag  in  IN_W  signed DFT output sample.
REQ-008 SHALL have port in_exp  in  EXP_W  unsigned block exponent for the current beat.
REQ-009 SHALL have port size  in  6  DFT size index 0..33, sampled at each accepted sop.
REQ-010 SHALL have ports out_valid/out_sop/out_eop  out  1 each  denormalised beat qualifiers.
REQ-011 SHALL have ports out_real/out_imag  out  OUT_W  signed value of in_x * 2^in_exp.
REQ-012 SHALL have port frame_err  out  1  one-cycle pulse on any framing violation.
REQ-013 SHALL have port sat_flag  out  1  high on an out_valid beat where either component saturated.

Function
REQ-014 SHALL compute out = sign-extended in * 2^in_exp per beat, using that beat's in_exp.
REQ-015 SHALL have a fixed 2-cycle latency from an accepted in beat to its out beat, with no backpressure.
REQ-016 SHALL map size to frame length through the shared table: 0->12, 1->24, 2->36, 3->48, 4->60, 5->72, 6->96, 7->108, 8->120, 9->144, 10->180, 11->192, 12->216, 13->240, 14->288, 15->300, 16->324, 17->360, 18->384, 19->432, 20->480, 21->540, 22->576, 23->600, 24->648, 25->720, 26->768, 27->864, 28->900, 29->960, 30->972, 31->1080, 32->1152, 33->1200; 34..63->12.
REQ-017 SHALL implement an FSM with two states, IDLE and RUN, and an 11-bit beat counter.
REQ-018 IDLE: in_valid&in_sop SHALL latch the expected length, set the counter to 1, forward the beat with out_sop, and enter RUN.
REQ-019 IDLE: in_valid without in_sop SHALL drop the beat (no out_valid) and pulse frame_err.
REQ-020 RUN: in_valid without sop or eop SHALL forward the beat, increment the counter, and pulse frame_err if the counter would exceed the expected length.
REQ-021 RUN: in_valid&in_eop SHALL forward the beat with out_eop, pulse frame_err if counter+1 differs from the expected length, and return to IDLE.
REQ-022 RUN: in_valid&in_sop SHALL pulse frame_err for the truncated frame and restart per REQ-018; the prior frame gets no out_eop.
REQ-023 sop&eop on the same beat SHALL forward with both flags set, pulse frame_err, and leave the FSM in IDLE.
REQ-024 in_sop/in_eop without in_valid SHALL be ignored.
REQ-025 frame_err SHALL be aligned with the out beat of the offending input, or with the would-be out cycle for dropped beats.

Reset
REQ-026 On rst, out_valid/out_sop/out_eop/frame_err/sat_flag SHALL be 0, out_real/out_imag 0, FSM IDLE, counter 0.
REQ-027 Reset mid-frame SHALL discard in-flight pipeline beats; the first beat after release must carry sop.

Configuration
REQ-028 With macro DFT_BFP_SAT_EN defined, results outside the OUT_W signed range SHALL clamp to max/min and raise sat_flag.
REQ-029 Without DFT_BFP_SAT_EN, results SHALL wrap (low OUT_W bits kept) and sat_flag SHALL be tied 0.

Structure
REQ-030 A shared package SHALL hold the 34-entry size-to-length table, the 1200 maximum-length constant, and the FSM state enum.
REQ-031 One sub-module, dft_bfp_shift_sat (one component: shift plus optional clamp), SHALL be instantiated twice, once for real and once for imag.

Verification
REQ-032 size=0, 12-beat frame, in_real=3, in_imag=-5, in_exp=2 -> 12 out beats 2 cycles later: out_real=12, out_imag=-20, sop on beat 1, eop on beat 12, frame_err=0.
REQ-033 in_real=131071, in_exp=15 with SAT_EN -> out_real=536870911, sat_flag=1; without SAT_EN -> wrapped low 30 bits, sat_flag=0.
REQ-034 size=33 frame with eop on beat 1199 -> frame_err pulse aligned with the eop out beat; FSM back in IDLE.
REQ-035 valid beat with no preceding sop -> no out_valid, frame_err pulse 2 cycles later; a following sop frame processes normally.
REQ-036 rst asserted at beat 500 of a 1200 frame -> all outputs 0 within one cycle; post-reset non-sop beats dropped with frame_err.
REQ-037 sop at beat 30 of a size=3 (48) frame -> frame_err pulse, new out_sop, and a clean 48-beat frame follows.

Source files
------------

// File: rtl/dft_bfp_denorm_pkg.sv
// Shared definitions for the DFT block-floating-point denormaliser:
// size-to-length table, maximum frame length and FSM state encoding.
package dft_bfp_denorm_pkg;

  localparam int unsigned N_SIZES = 34;
  localparam int unsigned MAX_LEN = 1200;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned SIZE_W  = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LEN_TAB [N_SIZES] = '{
    11'd12,   11'd24,   11'd36,   11'd48,   11'd60,   11'd72,   11'd96,
    11'd108,  11'd120,  11'd144,  11'd180,  11'd192,  11'd216,  11'd240,
    11'd288,  11'd300,  11'd324,  11'd360,  11'd384,  11'd432,  11'd480,
    11'd540,  11'd576,  11'd600,  11'd648,  11'd720,  11'd768,  11'd864,
    11'd900,  11'd960,  11'd972,  11'd1080, 11'd1152, 11'd1200
  };

  // Out-of-range size indices fall back to the smallest frame.
  function automatic logic [CNT_W-1:0] size_to_len(input logic [SIZE_W-1:0] size);
    if (32'(size) < N_SIZES) return LEN_TAB[size];
    return CNT_W'(12);
  endfunction

endpackage

// File: rtl/dft_bfp_denorm_if.sv
// Beat interface between a DFT source and the denormaliser.
// master drives the input beat, slave (the denormaliser) drives the output beat.
interface dft_bfp_denorm_if
  import dft_bfp_denorm_pkg::*;
#(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 30,
  parameter int unsigned EXP_W = 4
);

  logic                    in_valid;
  logic                    in_sop;
  logic                    in_eop;
  logic signed [IN_W-1:0]  in_real;
  logic signed [IN_W-1:0]  in_imag;
  logic [EXP_W-1:0]        in_exp;
  logic [SIZE_W-1:0]       size;

  logic                    out_valid;
  logic                    out_sop;
  logic                    out_eop;
  logic signed [OUT_W-1:0] out_real;
  logic signed [OUT_W-1:0] out_imag;
  logic                    frame_err;
  logic                    sat_flag;

  modport master (
    output in_valid, in_sop, in_eop, in_real, in_imag, in_exp, size,
    input  out_valid, out_sop, out_eop, out_real, out_imag, frame_err, sat_flag
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_real, in_imag, in_exp, size,
    output out_valid, out_sop, out_eop, out_real, out_imag, frame_err, sat_flag
  );

endinterface

// File: rtl/dft_bfp_shift_sat.sv
// One component of the denormaliser: din * 2^exp_i into OUT_W bits.
// DFT_BFP_SAT_EN selects clamping with sat_c; otherwise the result wraps.
module dft_bfp_shift_sat #(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 30,
  parameter int unsigned EXP_W = 4
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic [EXP_W-1:0]        exp_i,
  output logic signed [OUT_W-1:0] dout_c,
  output logic                    sat_c
);

  localparam int unsigned FULL_W = IN_W + (1 << EXP_W) - 1;
  localparam int unsigned WIDE_W = ((FULL_W > OUT_W) ? FULL_W : OUT_W) + 1;

`ifdef DFT_BFP_SAT_EN
  logic signed [WIDE_W-1:0] wide;
  logic                     ovf;

  // Overflow when the bits above the OUT_W sign bit are not all sign copies.
  always_comb begin
    wide   = WIDE_W'(din) << exp_i;
    ovf    = (wide[WIDE_W-1:OUT_W-1] != {(WIDE_W-OUT_W+1){wide[WIDE_W-1]}});
    sat_c  = ovf;
    dout_c = wide[OUT_W-1:0];
    if (ovf) begin
      dout_c = wide[WIDE_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    dout_c = OUT_W'(WIDE_W'(din) << exp_i);
    sat_c  = 1'b0;
  end
`endif

endmodule

// File: rtl/dft_bfp_denorm.sv
// Block-floating-point denormaliser with frame checking, 2-cycle latency.
// Define DFT_BFP_SAT_EN to clamp out-of-range results and raise sat_flag.
module dft_bfp_denorm
  import dft_bfp_denorm_pkg::*;
#(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 30,
  parameter int unsigned EXP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  dft_bfp_denorm_if.slave   bus
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                    s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d;
  logic                    s1_eop_q, s1_eop_d, s1_err_q, s1_err_d;
  logic signed [IN_W-1:0]  s1_real_q, s1_real_d, s1_imag_q, s1_imag_d;
  logic [EXP_W-1:0]        s1_exp_q, s1_exp_d;
  logic                    out_valid_q, out_valid_d, out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d, out_err_q, out_err_d;
  logic                    out_sat_q, out_sat_d;
  logic signed [OUT_W-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic signed [OUT_W-1:0] real_c, imag_c;
  logic                    sat_real_c, sat_imag_c;

  dft_bfp_shift_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) u_shift_real (
    .din(s1_real_q), .exp_i(s1_exp_q), .dout_c(real_c), .sat_c(sat_real_c)
  );

  dft_bfp_shift_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) u_shift_imag (
    .din(s1_imag_q), .exp_i(s1_exp_q), .dout_c(imag_c), .sat_c(sat_imag_c)
  );

  // Stage 1: framing FSM decides forward/drop/error; stage 2: shifted result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    s1_valid_d = 1'b0;
    s1_sop_d   = 1'b0;
    s1_eop_d   = 1'b0;
    s1_err_d   = 1'b0;
    s1_real_d  = s1_real_q;
    s1_imag_d  = s1_imag_q;
    s1_exp_d   = s1_exp_q;
    cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    if (bus.in_valid) begin
      s1_real_d = bus.in_real;
      s1_imag_d = bus.in_imag;
      s1_exp_d  = bus.in_exp;
      if (bus.in_sop) begin
        // A sop in RUN truncates the running frame and restarts.
        len_d      = size_to_len(bus.size);
        cnt_d      = CNT_W'(1);
        s1_valid_d = 1'b1;
        s1_sop_d   = 1'b1;
        s1_err_d   = (state_q == ST_RUN) || bus.in_eop;
        if (bus.in_eop) begin
          s1_eop_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_RUN;
        end
      end else if (state_q == ST_IDLE) begin
        s1_err_d = 1'b1;
      end else if (bus.in_eop) begin
        s1_valid_d = 1'b1;
        s1_eop_d   = 1'b1;
        s1_err_d   = (cnt_inc != len_q);
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end else begin
        s1_valid_d = 1'b1;
        s1_err_d   = (cnt_inc > len_q);
        cnt_d      = cnt_inc;
      end
    end

    out_valid_d = s1_valid_q;
    out_sop_d   = s1_sop_q;
    out_eop_d   = s1_eop_q;
    out_err_d   = s1_err_q;
    out_real_d  = real_c;
    out_imag_d  = imag_c;
    out_sat_d   = s1_valid_q && (sat_real_c || sat_imag_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_real_q   <= '0;
      s1_imag_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      s1_err_q    <= s1_err_d;
      s1_real_q   <= s1_real_d;
      s1_imag_q   <= s1_imag_d;
      s1_exp_q    <= s1_exp_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_sat_q   <= out_sat_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.frame_err = out_err_q;
  assign bus.sat_flag  = out_sat_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;

endmodule
